// File: rtl/niosii_timer_service_master.sv
// niosii_timer_service_master: Avalon-MM master that programs the 16-bit
// interval timer, services every timeout IRQ and publishes tick + snapshot.
// Ports: clk, reset (async, active-high); start/stop/period_in control;
// m_address/m_chipselect/m_write_n/m_read_n/m_writedata/m_readdata to the
// timer s1 slave; irq_in timer IRQ; busy/tick/tick_count/snapshot results.
module niosii_timer_service_master #(
  parameter int READ_LATENCY = 1,
  parameter int MIN_PERIOD   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] period_in,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic        m_read_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        irq_in,
  output logic        busy,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot
);

  typedef enum logic [3:0] {
    IDLE, WR_PERL, WR_PERH, WR_CTRL,
    WAIT_IRQ, CLR_STAT, WR_SNAP,
    RD_SNAPL, WAIT_L, RD_SNAPH, WAIT_H,
    DONE, WR_STOP
  } state_e;

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic        rn;
    logic [2:0]  addr;
    logic [15:0] wd;
  } bus_t;

  localparam bus_t BUS_IDLE =
    '{cs: 1'b0, wn: 1'b1, rn: 1'b1,
      addr: 3'd0, wd: 16'h0};
  localparam logic [31:0] MINP =
    32'(MIN_PERIOD);
  localparam logic [7:0] LAT_LAST =
    8'(READ_LATENCY - 1);

  function automatic bus_t wr(
    input logic [2:0]  a,
    input logic [15:0] d
  );
    return '{cs: 1'b1, wn: 1'b0, rn: 1'b1,
             addr: a, wd: d};
  endfunction

  function automatic bus_t rd(
    input logic [2:0] a
  );
    return '{cs: 1'b1, wn: 1'b1, rn: 1'b0,
             addr: a, wd: 16'h0};
  endfunction

  state_e      state;
  bus_t        bus;
  logic [31:0] load;
  logic [15:0] snap_lo;
  logic [7:0]  lat_cnt;
  logic        stop_pend;
  logic [31:0] eff;
  logic [31:0] ld_now;

  assign eff    = (period_in < MINP) ? MINP : period_in;
  assign ld_now = eff - 32'd1;

  // Bus outputs come straight from the registered bundle; the
  // bundle is loaded on entry to each access state.
  assign m_chipselect = bus.cs;
  assign m_write_n    = bus.wn;
  assign m_read_n     = bus.rn;
  assign m_address    = bus.addr;
  assign m_writedata  = bus.wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bus        <= BUS_IDLE;
      busy       <= 1'b0;
      tick       <= 1'b0;
      tick_count <= 32'h0;
      snapshot   <= 32'h0;
      load       <= 32'h0;
      snap_lo    <= 16'h0;
      lat_cnt    <= 8'h0;
      stop_pend  <= 1'b0;
    end else begin
      bus  <= BUS_IDLE;
      tick <= 1'b0;
      // Stop seen anywhere but IDLE is honoured once the
      // current sequence reaches a safe point.
      if (stop && state != IDLE)
        stop_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            load  <= ld_now;
            busy  <= 1'b1;
            state <= WR_PERL;
            bus   <= wr(3'd2, ld_now[15:0]);
          end
        end
        WR_PERL: begin
          state <= WR_PERH;
          bus   <= wr(3'd3, load[31:16]);
        end
        WR_PERH: begin
          state <= WR_CTRL;
          bus   <= wr(3'd1, 16'h0007);
        end
        WR_CTRL: state <= WAIT_IRQ;
        WAIT_IRQ: begin
          if (stop || stop_pend) begin
            state <= WR_STOP;
            bus   <= wr(3'd1, 16'h0008);
          end else if (irq_in) begin
            state <= CLR_STAT;
            bus   <= wr(3'd0, 16'h0000);
          end
        end
        CLR_STAT: begin
          state <= WR_SNAP;
          bus   <= wr(3'd4, 16'h0000);
        end
        WR_SNAP: begin
          state <= RD_SNAPL;
          bus   <= rd(3'd4);
        end
        RD_SNAPL: begin
          state   <= WAIT_L;
          lat_cnt <= 8'h0;
        end
        WAIT_L: begin
          if (lat_cnt == LAT_LAST) begin
            snap_lo <= m_readdata;
            state   <= RD_SNAPH;
            bus     <= rd(3'd5);
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        RD_SNAPH: begin
          state   <= WAIT_H;
          lat_cnt <= 8'h0;
        end
        WAIT_H: begin
          if (lat_cnt == LAT_LAST) begin
            snapshot   <= {m_readdata, snap_lo};
            tick_count <= tick_count + 32'd1;
            tick       <= 1'b1;
            state      <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        DONE: begin
          if (stop || stop_pend) begin
            state <= WR_STOP;
            bus   <= wr(3'd1, 16'h0008);
          end else begin
            state <= WAIT_IRQ;
          end
        end
        WR_STOP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          stop_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
